// File: rtl/ds_width_expander_pkt.sv
// Packet-aware upsizing width converter: packs FACTOR inbound words into one
// outbound word, flushing a partial word with keep flags on end-of-packet.
module ds_width_expander_pkt #(
  parameter int IWIDTH    = 8,
  parameter int FACTOR    = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IWIDTH-1:0]        i_dat,
  input  logic                     i_eop,
  input  logic                     i_val,
  output logic                     i_rdy,
  output logic [IWIDTH*FACTOR-1:0] o_dat,
  output logic [FACTOR-1:0]        o_keep,
  output logic                     o_eop,
  output logic                     o_val,
  input  logic                     o_rdy
);

  localparam int CW = $clog2(FACTOR);
  localparam int OW = IWIDTH * FACTOR;

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [FACTOR-2:0][IWIDTH-1:0] acc_q, acc_d;
  logic [FACTOR-2:0]             keep_q, keep_d;
  logic [OW-1:0]                 o_dat_q, o_dat_d;
  logic [FACTOR-1:0]             o_keep_q, o_keep_d;
  logic                          o_eop_q, o_eop_d;
  logic                          o_val_q, o_val_d;

  // Group assembled in arrival order, with the current word merged in
  logic [FACTOR-1:0][IWIDTH-1:0] grp;
  logic [FACTOR-1:0]             grp_keep;
  logic                          in_xfer;
  logic                          last_lane;

  assign i_rdy     = ~reset & (~o_val_q | o_rdy);
  assign in_xfer   = i_val & i_rdy;
  assign last_lane = (cnt_q == CW'(FACTOR - 1));

  always_comb begin
    grp      = {{IWIDTH{1'b0}}, acc_q};
    grp_keep = {1'b0, keep_q};
    for (int g = 0; g < FACTOR; g++) begin
      if (cnt_q == CW'(g)) begin
        grp[g]      = i_dat;
        grp_keep[g] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    keep_d   = keep_q;
    o_dat_d  = o_dat_q;
    o_keep_d = o_keep_q;
    o_eop_d  = o_eop_q;
    o_val_d  = o_val_q;

    if (o_val_q && o_rdy) begin
      o_val_d = 1'b0;
    end

    if (in_xfer) begin
      if (last_lane || i_eop) begin
        // Map arrival order onto physical lanes
        for (int g = 0; g < FACTOR; g++) begin
          o_dat_d[((LSB_FIRST != 0) ? g : FACTOR - 1 - g) * IWIDTH +: IWIDTH] = grp[g];
          o_keep_d[(LSB_FIRST != 0) ? g : FACTOR - 1 - g]                     = grp_keep[g];
        end
        o_eop_d = i_eop;
        o_val_d = 1'b1;
        acc_d   = '0;
        keep_d  = '0;
        cnt_d   = '0;
      end else begin
        for (int g = 0; g < FACTOR - 1; g++) begin
          if (cnt_q == CW'(g)) begin
            acc_d[g]  = i_dat;
            keep_d[g] = 1'b1;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      keep_q   <= '0;
      o_dat_q  <= '0;
      o_keep_q <= '0;
      o_eop_q  <= 1'b0;
      o_val_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      keep_q   <= keep_d;
      o_dat_q  <= o_dat_d;
      o_keep_q <= o_keep_d;
      o_eop_q  <= o_eop_d;
      o_val_q  <= o_val_d;
    end
  end

  assign o_dat  = o_dat_q;
  assign o_keep = o_keep_q;
  assign o_eop  = o_eop_q;
  assign o_val  = o_val_q;

endmodule

// File: tb/tb_ds_width_expander_pkt.sv
// Bench for ds_width_expander_pkt: three configurations share one stimulus,
// directed packet scenarios plus a randomized scoreboard run.
module tb_ds_width_expander_pkt;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_dat;
  logic       i_eop, i_val, o_rdy;

  logic        rdy0, eop0, val0;
  logic [31:0] dat0;
  logic [3:0]  keep0;
  logic        rdy1, eop1, val1;
  logic [31:0] dat1;
  logic [3:0]  keep1;
  logic        rdy2, eop2, val2;
  logic [23:0] dat2;
  logic [2:0]  keep2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ds_width_expander_pkt #(.IWIDTH(8), .FACTOR(4), .LSB_FIRST(1)) dut0 (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_eop(i_eop), .i_val(i_val), .i_rdy(rdy0),
    .o_dat(dat0), .o_keep(keep0), .o_eop(eop0), .o_val(val0), .o_rdy(o_rdy));

  ds_width_expander_pkt #(.IWIDTH(8), .FACTOR(4), .LSB_FIRST(0)) dut1 (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_eop(i_eop), .i_val(i_val), .i_rdy(rdy1),
    .o_dat(dat1), .o_keep(keep1), .o_eop(eop1), .o_val(val1), .o_rdy(o_rdy));

  ds_width_expander_pkt #(.IWIDTH(8), .FACTOR(3), .LSB_FIRST(1)) dut2 (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_eop(i_eop), .i_val(i_val), .i_rdy(rdy2),
    .o_dat(dat2), .o_keep(keep2), .o_eop(eop2), .o_val(val2), .o_rdy(o_rdy));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_val = 1'b0;
    i_eop = 1'b0;
    i_dat = '0;
    o_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic e);
    @(negedge clk);
    i_val = 1'b1;
    i_dat = d;
    i_eop = e;
  endtask

  task automatic idle();
    @(negedge clk);
    i_val = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_val got=%b exp=0", val0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat0); end
    checks++; if (keep0 !== 4'h0) begin errors++; $display("FAIL reset_keep got=%b exp=0", keep0); end
    checks++; if (eop0 !== 1'b0) begin errors++; $display("FAIL reset_eop got=%b exp=0", eop0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_rdy_held got=%b exp=0", rdy0); end
    reset = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy_release got=%b exp=1", rdy0); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(8'(i), i == 8);
      if (i == 5) begin
        checks++; if (val0 !== 1'b1) begin errors++; $display("FAIL stream_w0_val got=%b exp=1", val0); end
        checks++; if ({dat0, keep0, eop0} !== {32'h04030201, 4'hF, 1'b0}) begin
          errors++; $display("FAIL stream_w0 got=%h/%b/%b exp=04030201/1111/0", dat0, keep0, eop0); end
      end
      if (i == 6) begin
        checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL stream_gap_val got=%b exp=0", val0); end
      end
    end
    idle();
    checks++; if ({val0, dat0, keep0, eop0} !== {1'b1, 32'h08070605, 4'hF, 1'b1}) begin
      errors++; $display("FAIL stream_w1 got=%b/%h/%b/%b exp=1/08070605/1111/1", val0, dat0, keep0, eop0); end
  endtask

  task automatic test_partial();
    do_reset();
    drive(8'hAA, 1'b0);
    drive(8'hBB, 1'b0);
    drive(8'hCC, 1'b1);
    idle();
    checks++; if ({val0, dat0, keep0, eop0} !== {1'b1, 32'h00CCBBAA, 4'b0111, 1'b1}) begin
      errors++; $display("FAIL partial_3 got=%b/%h/%b/%b exp=1/00ccbbaa/0111/1", val0, dat0, keep0, eop0); end
    drive(8'h11, 1'b1);
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL partial_drain_val got=%b exp=0", val0); end
    idle();
    checks++; if ({val0, dat0, keep0, eop0} !== {1'b1, 32'h00000011, 4'b0001, 1'b1}) begin
      errors++; $display("FAIL partial_1 got=%b/%h/%b/%b exp=1/00000011/0001/1", val0, dat0, keep0, eop0); end
  endtask

  task automatic test_lsb_last();
    do_reset();
    drive(8'h01, 1'b0);
    drive(8'h02, 1'b0);
    drive(8'h03, 1'b1);
    idle();
    checks++; if ({val1, dat1, keep1, eop1} !== {1'b1, 32'h01020300, 4'b1110, 1'b1}) begin
      errors++; $display("FAIL msb_first got=%b/%h/%b/%b exp=1/01020300/1110/1", val1, dat1, keep1, eop1); end
    checks++; if ({dat0, keep0} !== {32'h00030201, 4'b0111}) begin
      errors++; $display("FAIL lsb_first_same got=%h/%b exp=00030201/0111", dat0, keep0); end
  endtask

  task automatic test_factor3();
    logic [23:0] exp_w;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(8'(i + 1), 1'b0);
      if (i >= 1) begin
        checks++; if (val2 !== ((i % 3) == 0)) begin
          errors++; $display("FAIL f3_val_%0d got=%b exp=%b", i, val2, (i % 3) == 0); end
      end
      if (i >= 3 && (i % 3) == 0) begin
        exp_w = {8'(i), 8'(i - 1), 8'(i - 2)};
        checks++; if ({dat2, keep2, eop2} !== {exp_w, 3'b111, 1'b0}) begin
          errors++; $display("FAIL f3_word_%0d got=%h/%b/%b exp=%h/111/0", i, dat2, keep2, eop2, exp_w); end
      end
    end
    idle();
    checks++; if ({val2, dat2, keep2, eop2} !== {1'b1, 24'h090807, 3'b111, 1'b0}) begin
      errors++; $display("FAIL f3_last got=%b/%h/%b/%b exp=1/090807/111/0", val2, dat2, keep2, eop2); end
  endtask

  task automatic test_backpressure();
    do_reset();
    o_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) drive(8'(i), 1'b0);
    drive(8'h05, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_rdy_%0d got=%b exp=0", k, rdy0); end
      checks++; if ({val0, dat0, keep0, eop0} !== {1'b1, 32'h04030201, 4'hF, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d got=%b/%h/%b/%b exp=1/04030201/1111/0", k, val0, dat0, keep0, eop0); end
      @(negedge clk);
    end
    o_rdy = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", rdy0); end
    @(negedge clk);
    i_val = 1'b0;
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL bp_drained_val got=%b exp=0", val0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(8'hA1, 1'b0);
    drive(8'hA2, 1'b0);
    @(negedge clk);
    i_val = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({val0, rdy0} !== 2'b00) begin errors++; $display("FAIL midrst_val_rdy got=%b%b exp=00", val0, rdy0); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(8'hB0 + 8'(i), 1'b0);
      if (i >= 3) begin
        checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL midrst_noflush_%0d got=%b exp=0", i, val0); end
      end
    end
    idle();
    checks++; if ({val0, dat0, keep0, eop0} !== {1'b1, 32'hB4B3B2B1, 4'hF, 1'b0}) begin
      errors++; $display("FAIL midrst_word got=%b/%h/%b/%b exp=1/b4b3b2b1/1111/0", val0, dat0, keep0, eop0); end
  endtask

  task automatic test_random();
    logic [36:0] expq[$];
    logic [7:0]  grpw[$];
    logic [36:0] e;
    logic [31:0] d;
    logic [3:0]  k;
    int acc = 0;
    int cyc = 0;
    do_reset();
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      i_val = ($urandom_range(0, 3) != 0);
      o_rdy = ($urandom_range(0, 3) != 0);
      i_dat = 8'($urandom);
      i_eop = (acc == 999) || ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (rdy0 !== (!val0 || o_rdy)) begin
        errors++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, rdy0, !val0 || o_rdy); end
      if (val0 && o_rdy) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got=%h/%b/%b exp=none", cyc, dat0, keep0, eop0);
        end else begin
          e = expq.pop_front();
          if ({dat0, keep0, eop0} !== e) begin
            errors++; $display("FAIL rnd_word cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc, dat0, keep0, eop0, e[36:5], e[4:1], e[0]); end
        end
      end
      if (i_val && rdy0) begin
        grpw.push_back(i_dat);
        acc++;
        if (grpw.size() == 4 || i_eop) begin
          d = '0;
          k = '0;
          for (int g = 0; g < grpw.size(); g++) begin
            d[g*8 +: 8] = grpw[g];
            k[g]        = 1'b1;
          end
          expq.push_back({d, k, i_eop});
          grpw.delete();
        end
      end
      cyc++;
    end
    checks++; if (acc < 1000) begin errors++; $display("FAIL rnd_timeout accepted=%0d exp=1000", acc); end
    repeat (4) begin
      @(negedge clk);
      i_val = 1'b0;
      o_rdy = 1'b1;
      #1;
      if (val0) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_drain_extra got=%h exp=none", dat0);
        end else begin
          e = expq.pop_front();
          if ({dat0, keep0, eop0} !== e) begin
            errors++; $display("FAIL rnd_drain_word got=%h/%b/%b exp=%h/%b/%b", dat0, keep0, eop0, e[36:5], e[4:1], e[0]); end
        end
      end
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d left exp=0", expq.size()); end
  endtask

  initial begin
    i_dat = '0;
    i_eop = 1'b0;
    i_val = 1'b0;
    o_rdy = 1'b1;
    test_reset();
    test_stream();
    test_partial();
    test_lsb_last();
    test_factor3();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
